// File: rtl/vga_pkg.sv
// vga_pkg: shared 800x600@60 timing constants, configuration struct and FSM state type
package vga_pkg;
    localparam int VGA_H_TOTAL     = 1056;
    localparam int VGA_H_SYNC      = 128;
    localparam int VGA_H_ACT_START = 216;
    localparam int VGA_H_ACT_END   = 1016;
    localparam int VGA_V_TOTAL     = 628;
    localparam int VGA_V_SYNC      = 4;
    localparam int VGA_V_ACT_START = 27;
    localparam int VGA_V_ACT_END   = 627;

    typedef logic [11:0] rgb444_t;

    typedef struct packed {
        logic [10:0] x0;
        logic [10:0] x1;
        logic [9:0]  y0;
        logic [9:0]  y1;
        rgb444_t     fg;
        rgb444_t     bg;
    } vga_cfg_t;

    typedef enum logic {IDLE, PENDING} cfg_state_t;
endpackage

// File: rtl/vga_raster_counter.sv
// vga_raster_counter: pixel-tick divider plus horizontal/vertical raster counters
// ports: clk, rst (async, high), en (hold at 0 when low); tick, frame_end (last tick of frame), hcount, vcount
module vga_raster_counter #(
    parameter int CLK_DIV = 2,
    parameter int H_TOTAL = 1056,
    parameter int V_TOTAL = 628
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        tick,
    output logic        frame_end,
    output logic [10:0] hcount,
    output logic [9:0]  vcount
);
    // one extra bit so CLK_DIV=1 still yields a legal 1-bit divider
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);
    localparam logic [10:0] HMAX = 11'(H_TOTAL - 1);
    localparam logic [9:0]  VMAX = 10'(V_TOTAL - 1);

    logic [DW-1:0] div;

    assign tick      = en && div == DMAX;
    assign frame_end = tick && hcount == HMAX && vcount == VMAX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || !en) begin
            div    <= '0;
            hcount <= '0;
            vcount <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                hcount <= hcount == HMAX ? '0 : hcount + 1'b1;
                if (hcount == HMAX)
                    vcount <= vcount == VMAX ? '0 : vcount + 1'b1;
            end
        end
    end
endmodule

// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler: VGA raster with frame-synchronous configuration commit
// ports: clk, rst (async, high), en; cfg_valid/cfg_ready handshake with cfg_x0/x1/y0/y1/fg/bg;
//        hsync, vsync, red, green, blue, frame_start, cfg_applied, led
module vga_frame_scheduler
    import vga_pkg::*;
#(
    parameter int      CLK_DIV     = 2,
    parameter int      H_TOTAL     = VGA_H_TOTAL,
    parameter int      H_SYNC      = VGA_H_SYNC,
    parameter int      H_ACT_START = VGA_H_ACT_START,
    parameter int      H_ACT_END   = VGA_H_ACT_END,
    parameter int      V_TOTAL     = VGA_V_TOTAL,
    parameter int      V_SYNC      = VGA_V_SYNC,
    parameter int      V_ACT_START = VGA_V_ACT_START,
    parameter int      V_ACT_END   = VGA_V_ACT_END,
    parameter int      RST_X0      = 216,
    parameter int      RST_X1      = 1016,
    parameter int      RST_Y0      = 27,
    parameter int      RST_Y1      = 627,
    parameter rgb444_t RST_FG      = 12'hFFF,
    parameter rgb444_t RST_BG      = 12'h666
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [10:0] cfg_x0,
    input  logic [10:0] cfg_x1,
    input  logic [9:0]  cfg_y0,
    input  logic [9:0]  cfg_y1,
    input  logic [11:0] cfg_fg,
    input  logic [11:0] cfg_bg,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        frame_start,
    output logic        cfg_applied,
    output logic        led
);
    localparam logic [10:0] HS  = 11'(H_SYNC);
    localparam logic [10:0] HA0 = 11'(H_ACT_START);
    localparam logic [10:0] HA1 = 11'(H_ACT_END);
    localparam logic [9:0]  VS  = 10'(V_SYNC);
    localparam logic [9:0]  VA0 = 10'(V_ACT_START);
    localparam logic [9:0]  VA1 = 10'(V_ACT_END);
    localparam vga_cfg_t RST_CFG = '{x0: 11'(RST_X0), x1: 11'(RST_X1),
                                     y0: 10'(RST_Y0), y1: 10'(RST_Y1),
                                     fg: RST_FG, bg: RST_BG};

    logic        tick, frame_end, in_active, in_window;
    logic [10:0] h;
    logic [9:0]  v;
    rgb444_t     pix;
    vga_cfg_t    act, shadow;
    cfg_state_t  state;

    vga_raster_counter #(.CLK_DIV(CLK_DIV), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)) u_cnt (
        .clk(clk), .rst(rst), .en(en), .tick(tick), .frame_end(frame_end),
        .hcount(h), .vcount(v)
    );

    // degenerate windows (x0>=x1 or y0>=y1) fall out naturally as never-inside
    always_comb begin
        in_active = h >= HA0 && h < HA1 && v >= VA0 && v < VA1;
        in_window = h >= act.x0 && h < act.x1 && v >= act.y0 && v < act.y1;
        pix       = !in_active ? '0 : in_window ? act.fg : act.bg;
    end

    // outputs show the pre-tick counter position, one tick behind the counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync              <= 1'b0;
            vsync              <= 1'b0;
            {red, green, blue} <= '0;
            frame_start        <= 1'b0;
        end else begin
            frame_start <= frame_end;
            if (!en) begin
                hsync              <= 1'b0;
                vsync              <= 1'b0;
                {red, green, blue} <= '0;
            end else if (tick) begin
                hsync              <= h < HS;
                vsync              <= v < VS;
                {red, green, blue} <= pix;
            end
        end
    end

    // a stopped raster has no frame to protect, so a pending config commits at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cfg_ready   <= 1'b1;
            led         <= 1'b0;
            cfg_applied <= 1'b0;
            act         <= RST_CFG;
            shadow      <= RST_CFG;
        end else begin
            cfg_applied <= 1'b0;
            if (state == IDLE) begin
                if (cfg_valid && cfg_ready) begin
                    shadow    <= '{x0: cfg_x0, x1: cfg_x1, y0: cfg_y0, y1: cfg_y1, fg: cfg_fg, bg: cfg_bg};
                    state     <= PENDING;
                    cfg_ready <= 1'b0;
                    led       <= 1'b1;
                end
            end else if (frame_end || !en) begin
                act         <= shadow;
                cfg_applied <= 1'b1;
                state       <= IDLE;
                cfg_ready   <= 1'b1;
                led         <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb_vga_frame_scheduler: randomized scoreboard bench for vga_frame_scheduler on a shrunken raster
module tb_vga_frame_scheduler;
    localparam int DIV = 2, HT = 20, HS = 3, HA0 = 4, HA1 = 18;
    localparam int VT = 12, VS = 2, VA0 = 2, VA1 = 11;
    localparam int RX0 = 4, RX1 = 18, RY0 = 2, RY1 = 11;
    localparam logic [11:0] RFG = 12'hFFF, RBG = 12'h666;

    typedef struct packed {
        logic        hs, vs;
        logic [11:0] rgb;
        logic        fs, ca, rdy, led;
    } exp_t;

    typedef struct {
        int x0, x1, y0, y1;
        logic [11:0] fg, bg;
    } mcfg_t;

    localparam exp_t RESET_EXP = '{hs: 0, vs: 0, rgb: 0, fs: 0, ca: 0, rdy: 1, led: 0};

    logic clk = 0, rst = 1, en = 0, cfg_valid = 0;
    logic [10:0] cx0 = 0, cx1 = 0;
    logic [9:0]  cy0 = 0, cy1 = 0;
    logic [11:0] cfg = 0, cbg = 0;
    logic cfg_ready, hsync, vsync, frame_start, cfg_applied, led;
    logic [3:0] red, green, blue;

    exp_t  q[$];
    int    nvec = 0, nerr = 0;

    always #5 clk = ~clk;

    vga_frame_scheduler #(
        .CLK_DIV(DIV), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HA0), .H_ACT_END(HA1),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VA0), .V_ACT_END(VA1),
        .RST_X0(RX0), .RST_X1(RX1), .RST_Y0(RY0), .RST_Y1(RY1), .RST_FG(RFG), .RST_BG(RBG)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_x0(cx0), .cfg_x1(cx1), .cfg_y0(cy0), .cfg_y1(cy1), .cfg_fg(cfg), .cfg_bg(cbg),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .frame_start(frame_start), .cfg_applied(cfg_applied), .led(led)
    );

    initial begin
        int c, t, h, v;
        bit pend, commit;
        mcfg_t act, shd;
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                c = 0; pend = 0; e = RESET_EXP;
                act = '{RX0, RX1, RY0, RY1, RFG, RBG};
                shd = act;
                q.delete();
            end else begin
                commit = 0; e.fs = 0; e.ca = 0;
                if (!en) begin
                    c = 0; e.hs = 0; e.vs = 0; e.rgb = 0;
                    commit = pend;
                end else begin
                    c++;
                    if (c % DIV == 0) begin
                        t = c / DIV - 1;
                        h = t % HT;
                        v = (t / HT) % VT;
                        e.hs = h < HS;
                        e.vs = v < VS;
                        if (h >= HA0 && h < HA1 && v >= VA0 && v < VA1)
                            e.rgb = (h >= act.x0 && h < act.x1 && v >= act.y0 && v < act.y1) ? act.fg : act.bg;
                        else
                            e.rgb = 0;
                        e.fs = h == HT - 1 && v == VT - 1;
                        commit = pend && e.fs;
                    end
                end
                if (commit) begin
                    act = shd; pend = 0; e.ca = 1;
                end else if (cfg_valid && !pend) begin
                    shd = '{int'(cx0), int'(cx1), int'(cy0), int'(cy1), cfg, cbg};
                    pend = 1;
                end
                e.rdy = !pend;
                e.led = pend;
                q.push_back(e);
            end
        end
    end

    initial begin
        exp_t got, want;
        forever begin
            @(negedge clk);
            got = '{hs: hsync, vs: vsync, rgb: {red, green, blue}, fs: frame_start,
                    ca: cfg_applied, rdy: cfg_ready, led: led};
            want = (rst || q.size() == 0) ? RESET_EXP : q.pop_front();
            nvec++;
            if (got !== want) begin
                nerr++;
                $display("FAIL outputs t=%0t got hs%b vs%b rgb%h fs%b ca%b rdy%b led%b, want hs%b vs%b rgb%h fs%b ca%b rdy%b led%b",
                         $time, got.hs, got.vs, got.rgb, got.fs, got.ca, got.rdy, got.led,
                         want.hs, want.vs, want.rgb, want.fs, want.ca, want.rdy, want.led);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rand_cfg();
        cx0 = 11'($urandom_range(0, HT + 1));
        cx1 = 11'($urandom_range(0, HT + 1));
        cy0 = 10'($urandom_range(0, VT + 1));
        cy1 = 10'($urandom_range(0, VT + 1));
        cfg = 12'($urandom);
        cbg = 12'($urandom);
    endtask

    task automatic offer(input int x0, input int x1, input int y0, input int y1,
                         input logic [11:0] fg, input logic [11:0] bg);
        @(negedge clk);
        cx0 = 11'(x0); cx1 = 11'(x1); cy0 = 10'(y0); cy1 = 10'(y1); cfg = fg; cbg = bg;
        cfg_valid = 1;
        @(negedge clk);
        cfg_valid = 0;
    endtask

    initial begin
        int w;
        step(3);
        rst = 0;
        en = 1;
        step(2 * HT * VT * DIV + 7);
        offer(5, RX1, RY0, RY1, RFG, RBG);
        w = 0;
        while (!cfg_applied && w < 2 * HT * VT * DIV + 10) begin
            @(negedge clk);
            w++;
        end
        if (!cfg_applied) begin
            nerr++;
            $display("FAIL timeout t=%0t: cfg_applied not seen within %0d clks", $time, w);
        end
        step(2 * HT * VT * DIV);
        step(137);
        offer(10, 14, 4, 8, 12'hF00, 12'h000);
        step(2 * HT * VT * DIV);
        cfg_valid = 1;
        repeat (3 * HT * VT * DIV) begin
            rand_cfg();
            @(negedge clk);
        end
        cfg_valid = 0;
        step(HT * DIV * 5 + 10 * DIV);
        rand_cfg();
        offer(int'(cx0), int'(cx1), int'(cy0), int'(cy1), cfg, cbg);
        step(5);
        en = 0;
        step(9);
        en = 1;
        step(HT * VT * DIV + 40);
        offer(1, 19, 1, 11, 12'h0F0, 12'h00F);
        step(HT * 6 * DIV);
        #2 rst = 1;
        step(3);
        if ({hsync, vsync, red, green, blue, frame_start, cfg_applied, led, cfg_ready} !== {19'b0, 1'b1}) begin
            nerr++;
            $display("FAIL reset state t=%0t: hs%b vs%b rgb%h fs%b ca%b led%b rdy%b",
                     $time, hsync, vsync, {red, green, blue}, frame_start, cfg_applied, led, cfg_ready);
        end
        rst = 0;
        step(HT * VT * DIV + 30);
        repeat (4000) begin
            @(negedge clk);
            en = en ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 9) == 0);
            cfg_valid = $urandom_range(0, 39) == 0;
            rand_cfg();
        end
        cfg_valid = 0;
        step(4);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/vga_frame_scheduler.md
# vga_frame_scheduler

Raster controller for the VGA output path. It divides the system clock into a pixel tick and runs the horizontal and vertical counters. It generates positive-polarity HSYNC and VSYNC and drives the 4:4:4 colour outputs from a window/colour configuration. New configurations arrive over a valid/ready handshake and take effect only at a frame boundary, so a mode change never tears a frame. It sits between the board-level control logic (switches, LED) and the VGA connector.

## Interface
Parameters:
- CLK_DIV, 2: system clocks per pixel tick (≥1).
- H_TOTAL, 1056; H_SYNC, 128; H_ACT_START, 216; H_ACT_END, 1016: horizontal timing in pixel ticks (800x600@60).
- V_TOTAL, 628; V_SYNC, 4; V_ACT_START, 27; V_ACT_END, 627: vertical timing in lines.
- RST_X0, 216; RST_X1, 1016; RST_Y0, 27; RST_Y1, 627; RST_FG, 12'hFFF; RST_BG, 12'h666: configuration loaded at reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active high.
- en  in  1  raster enable.
- cfg_valid  in  1  new configuration offered.
- cfg_ready  out  1  scheduler can accept a configuration.
- cfg_x0, cfg_x1  in  11 each  window column bounds, half-open [x0, x1).
- cfg_y0, cfg_y1  in  10 each  window line bounds, half-open [y0, y1).
- cfg_fg, cfg_bg  in  12 each  {R,G,B} 4 bits each, inside/outside window.
- hsync, vsync  out  1 each  sync pulses, high during sync.
- red, green, blue  out  4 each  pixel colour.
- frame_start  out  1  one-clk pulse on the tick where h=0, v=0.
- cfg_applied  out  1  one-clk pulse when shadow config is committed.
- led  out  1  high while a configuration is pending.

## Operation
- Tick: divider counts 0..CLK_DIV-1. The tick fires on the clk where the divider equals CLK_DIV-1. With CLK_DIV=1 the tick fires every clk.
- Counters: on each tick, hcount increments; at H_TOTAL-1 it wraps to 0 and vcount increments; vcount wraps to 0 at V_TOTAL-1.
- Sync: hsync = hcount < H_SYNC; vsync = vcount < V_SYNC.
- active = H_ACT_START ≤ hcount < H_ACT_END and V_ACT_START ≤ vcount < V_ACT_END.
- Colour: when not active, rgb = 0. When active and inside the window, rgb = fg. When active and outside the window, rgb = bg.
- Config FSM, two states:
  - IDLE: cfg_ready=1, led=0. cfg_valid with cfg_ready loads the shadow register and moves to PENDING.
  - PENDING: cfg_ready=0, led=1. On the next frame-boundary tick, shadow is copied to active, cfg_applied pulses, and the FSM returns to IDLE.
- Frame-boundary tick: the tick on which the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- en=0: divider and counters are held at 0. hsync, vsync and rgb are forced to 0 and frame_start does not fire. The handshake remains live. A PENDING configuration commits on the next clk rather than waiting for a frame.
- Degenerate window (x0 ≥ x1 or y0 ≥ y1) is legal and means no pixel is inside. It is not rejected.

## Timing
- Reset: divider, hcount and vcount = 0; FSM = IDLE; active config = RST_* values; shadow register = RST_* values.
- Reset values of outputs: hsync=vsync=0, rgb=0, frame_start=cfg_applied=led=0, cfg_ready=1.
- Outputs hsync, vsync, rgb and frame_start are registered and update on the tick clk. They reflect the counter values from before that tick, so latency is one tick.
- Commit: active config changes on the frame-boundary tick clk. The first pixel rendered with the new config is (0,0) of the following frame. cfg_applied and frame_start pulse on the same clk.
- cfg_valid on the commit clk while PENDING is not accepted because cfg_ready=0. cfg_ready returns to 1 on the next clk.
- cfg_valid accepted in IDLE on a frame-boundary clk does not commit that same clk. It waits one full frame.
- en falling mid-frame: the raster stops immediately. en rising restarts from (0,0) and the first tick is CLK_DIV clks later.
- rst asserted mid-frame or while PENDING: the shadow value is discarded and all state returns to reset values asynchronously.

## Structure
- Package vga_pkg:
  - 800x600 timing constants.
  - vga_cfg_t struct {x0, x1, y0, y1, fg, bg}.
  - rgb444_t typedef.
  - fsm state enum {IDLE, PENDING}.
- Sub-module vga_raster_counter: divider, tick, hcount/vcount and the frame-boundary flag.
- vga_frame_scheduler: the config FSM, the shadow and active registers, and the output registers.

## Test plan
- Reset then en=1, CLK_DIV=2: a tick fires every 2 clks; hsync is high for 128 ticks of every 1056; vsync is high for the first 4 lines of 628; frame_start occurs every 1056*628*2 clks.
- Default config: pixel (216,27) = FFF; pixel (215,27) = 000 because it is blanked; set window x0=300, then pixel (216,27) = 666.
- Config x0=400, x1=500, y0=100, y1=200, fg=F00, bg=000, sent mid-frame: cfg_ready drops and led=1; the current frame keeps the old colours; cfg_applied coincides with frame_start; the next frame shows F00 at (450,150) and 000 at (350,150).
- cfg_valid held high across the commit clk: exactly one accept per frame; a second config is accepted on the clk after cfg_applied and commits one frame later.
- en dropped at hcount=500: outputs go to 0 and counters hold at 0; with a pending config, cfg_applied fires on the next clk; after en rises, the raster restarts at (0,0).
- rst pulsed while PENDING at vcount=300: cfg_ready=1 and led=0; the active config equals the RST_* values; the raster restarts from (0,0).
